// File: rtl/iob_axis2axi_in.sv
// iob_axis2axi_in
// Drains a fixed number of 32-bit AXI-Stream beats into memory as AXI4 INCR
// write bursts. A config handshake supplies the byte start address and the
// word count. Each burst is capped at 2**BURST_W beats and, for address
// widths of 13 bits or more, never crosses a 4 KiB boundary.
//
// Ports:
//   clk_i, cke_i, arst_n_i           clock, clock enable, async active-low reset
//   config_in_*                      start address / length request (ready in IDLE)
//   axis_in_*                        stream input (passed through to W in DATA)
//   axi_aw*, axi_w*, axi_b*          AXI4 write channels (no read channels)
//   busy_o                           high whenever the FSM is not IDLE
//   error_o                          sticky, set on any non-OKAY write response
module iob_axis2axi_in #(
  parameter int AXI_ADDR_W = 16,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int BURST_W    = 3
) (
  input  logic                      clk_i,
  input  logic                      cke_i,
  input  logic                      arst_n_i,
  input  logic [AXI_ADDR_W-1:0]     config_in_addr_i,
  input  logic [AXI_ADDR_W-1:0]     config_in_length_i,
  input  logic                      config_in_valid_i,
  output logic                      config_in_ready_o,
  input  logic [AXI_DATA_W-1:0]     axis_in_data_i,
  input  logic                      axis_in_valid_i,
  output logic                      axis_in_ready_o,
  output logic [AXI_ID_W-1:0]       axi_awid_o,
  output logic [AXI_ADDR_W-1:0]     axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]      axi_awlen_o,
  output logic [2:0]                axi_awsize_o,
  output logic [1:0]                axi_awburst_o,
  output logic                      axi_awlock_o,
  output logic [3:0]                axi_awcache_o,
  output logic [3:0]                axi_awqos_o,
  output logic                      axi_awvalid_o,
  input  logic                      axi_awready_i,
  output logic [AXI_DATA_W-1:0]     axi_wdata_o,
  output logic [(AXI_DATA_W/8)-1:0] axi_wstrb_o,
  output logic                      axi_wlast_o,
  output logic                      axi_wvalid_o,
  input  logic                      axi_wready_i,
  input  logic [1:0]                axi_bresp_i,
  input  logic                      axi_bvalid_i,
  output logic                      axi_bready_o,
  output logic                      busy_o,
  output logic                      error_o
);

  localparam logic [AXI_ADDR_W-1:0] MAX_BURST = {{(AXI_ADDR_W-1){1'b0}}, 1'b1} << BURST_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t                r_state;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [AXI_ADDR_W-1:0] r_remaining;
  logic [AXI_LEN_W-1:0]  r_awlen;
  logic [AXI_LEN_W-1:0]  r_beat_cnt;
  logic                  r_error;
  logic                  r_awvalid;
  logic                  r_bready;
  logic                  r_cfg_ready;
  logic                  r_busy;
  logic                  r_data_en;

  logic [AXI_ADDR_W-1:0] w_size_len;
  logic [AXI_ADDR_W-1:0] w_size;
  logic [AXI_ADDR_W-1:0] w_burst_bytes;
  logic                  w_wlast;
  logic                  w_w_hs;

  // Burst length limited by the remaining word count and the burst cap.
  always_comb begin
    if (r_remaining < MAX_BURST) begin
      w_size_len = r_remaining;
    end else begin
      w_size_len = MAX_BURST;
    end
  end

  generate
    if (AXI_ADDR_W >= 13) begin : g_4k
      logic [12:0] w_to_4k_words;
      // Further limit the burst to the words left before the next 4 KiB page.
      always_comb begin
        w_to_4k_words = (13'h1000 - {1'b0, r_addr[11:0]}) >> 2;
        if (AXI_ADDR_W'(w_to_4k_words) < w_size_len) begin
          w_size = AXI_ADDR_W'(w_to_4k_words);
        end else begin
          w_size = w_size_len;
        end
      end
    end else begin : g_no4k
      assign w_size = w_size_len;
    end
  endgenerate

  // Bytes covered by the burst just completed; the address wraps naturally.
  assign w_burst_bytes = (AXI_ADDR_W'(r_awlen) + {{(AXI_ADDR_W-1){1'b0}}, 1'b1}) << 2;
  assign w_wlast       = (r_beat_cnt == r_awlen);
  assign w_w_hs        = r_data_en && axis_in_valid_i && axi_wready_i;

  // Control FSM; all handshake outputs are registered alongside the state.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_awlen     <= '0;
      r_beat_cnt  <= '0;
      r_error     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_data_en   <= 1'b0;
    end else if (cke_i) begin
      case (r_state)
        ST_IDLE: begin
          if (config_in_valid_i) begin
            r_addr      <= config_in_addr_i;
            r_remaining <= config_in_length_i;
            r_error     <= 1'b0;
            // A zero-length request is accepted but generates no traffic.
            if (config_in_length_i != '0) begin
              r_state     <= ST_CALC;
              r_cfg_ready <= 1'b0;
              r_busy      <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          r_awlen     <= AXI_LEN_W'(w_size - {{(AXI_ADDR_W-1){1'b0}}, 1'b1});
          r_remaining <= r_remaining - w_size;
          r_beat_cnt  <= '0;
          r_awvalid   <= 1'b1;
          r_state     <= ST_ADDR;
        end
        ST_ADDR: begin
          if (axi_awready_i) begin
            r_awvalid <= 1'b0;
            r_data_en <= 1'b1;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_w_hs) begin
            if (w_wlast) begin
              r_data_en <= 1'b0;
              r_bready  <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + {{(AXI_LEN_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_RESP: begin
          if (axi_bvalid_i) begin
            r_bready <= 1'b0;
            if (axi_bresp_i != 2'b00) begin
              r_error <= 1'b1;
            end
            r_addr <= r_addr + w_burst_bytes;
            // An error response does not abort the remaining bursts.
            if (r_remaining == '0) begin
              r_state     <= ST_IDLE;
              r_cfg_ready <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_awvalid   <= 1'b0;
          r_bready    <= 1'b0;
          r_data_en   <= 1'b0;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign config_in_ready_o = r_cfg_ready;
  assign busy_o            = r_busy;
  assign error_o           = r_error;

  assign axi_awid_o    = {AXI_ID_W{1'b0}};
  assign axi_awaddr_o  = r_addr;
  assign axi_awlen_o   = r_awlen;
  assign axi_awsize_o  = 3'd2;
  assign axi_awburst_o = 2'd1;
  assign axi_awlock_o  = 1'b0;
  assign axi_awcache_o = 4'd2;
  assign axi_awqos_o   = 4'd0;
  assign axi_awvalid_o = r_awvalid;

  // Stream-to-W pass-through, enabled only between AW handshake and last beat.
  assign axi_wdata_o     = axis_in_data_i;
  assign axi_wstrb_o     = {(AXI_DATA_W/8){1'b1}};
  assign axi_wlast_o     = w_wlast;
  assign axi_wvalid_o    = r_data_en && axis_in_valid_i;
  assign axis_in_ready_o = r_data_en && axi_wready_i;
  assign axi_bready_o    = r_bready;

endmodule

// File: tb/tb_iob_axis2axi_in.sv
module tb_iob_axis2axi_in;

  localparam int AW = 16;
  localparam int LW = 8;
  localparam int IW = 1;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          cke_i;
  logic          arst_n_i;
  logic [AW-1:0] config_in_addr_i;
  logic [AW-1:0] config_in_length_i;
  logic          config_in_valid_i;
  logic          config_in_ready_o;
  logic [31:0]   axis_in_data_i;
  logic          axis_in_valid_i;
  logic          axis_in_ready_o;
  logic [IW-1:0] axi_awid_o;
  logic [AW-1:0] axi_awaddr_o;
  logic [LW-1:0] axi_awlen_o;
  logic [2:0]    axi_awsize_o;
  logic [1:0]    axi_awburst_o;
  logic          axi_awlock_o;
  logic [3:0]    axi_awcache_o;
  logic [3:0]    axi_awqos_o;
  logic          axi_awvalid_o;
  logic          axi_awready_i;
  logic [31:0]   axi_wdata_o;
  logic [3:0]    axi_wstrb_o;
  logic          axi_wlast_o;
  logic          axi_wvalid_o;
  logic          axi_wready_i;
  logic [1:0]    axi_bresp_i;
  logic          axi_bvalid_i;
  logic          axi_bready_o;
  logic          busy_o;
  logic          error_o;

  always #5 clk = ~clk;

  iob_axis2axi_in #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(32), .AXI_LEN_W(LW), .AXI_ID_W(IW), .BURST_W(BW)
  ) dut (
    .clk_i(clk), .cke_i(cke_i), .arst_n_i(arst_n_i),
    .config_in_addr_i(config_in_addr_i), .config_in_length_i(config_in_length_i),
    .config_in_valid_i(config_in_valid_i), .config_in_ready_o(config_in_ready_o),
    .axis_in_data_i(axis_in_data_i), .axis_in_valid_i(axis_in_valid_i),
    .axis_in_ready_o(axis_in_ready_o),
    .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
    .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o), .axi_awlock_o(axi_awlock_o),
    .axi_awcache_o(axi_awcache_o), .axi_awqos_o(axi_awqos_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
    .busy_o(busy_o), .error_o(error_o)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Slave / source / monitor state
  logic [AW-1:0] aw_addr_log[$];
  logic [LW-1:0] aw_len_log[$];
  logic [31:0]   beat_log[$];
  bit            beat_last_log[$];
  int            n_axis, b_done, b_pending, aw_wait, cyc, bad_if, busy_high;
  bit            in_data;
  int            aw_delay  = 0;
  bit            gaps      = 1'b0;
  int            err_burst = -1;
  int            src_idx, src_len;
  logic [31:0]   src_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_logs();
    aw_addr_log.delete();
    aw_len_log.delete();
    beat_log.delete();
    beat_last_log.delete();
    n_axis = 0; b_done = 0; b_pending = 0; aw_wait = 0;
    bad_if = 0; busy_high = 0; in_data = 1'b0;
  endtask

  // One clock: drive at negedge, sample handshakes, then update after posedge.
  task automatic cycle();
    bit aw_hs, w_hs, w_last, ax_hs, b_hs, awv;
    axi_awready_i   = axi_awvalid_o && (aw_wait >= aw_delay);
    axi_wready_i    = gaps ? ((cyc % 3) != 1) : 1'b1;
    axis_in_valid_i = (src_idx < src_len) && (gaps ? ((cyc % 5) != 2) : 1'b1);
    axis_in_data_i  = src_base + 32'(src_idx);
    axi_bvalid_i    = (b_pending > 0);
    axi_bresp_i     = (b_done == err_burst) ? 2'b10 : 2'b00;
    #1;
    awv    = axi_awvalid_o;
    aw_hs  = axi_awvalid_o && axi_awready_i;
    w_hs   = axi_wvalid_o && axi_wready_i;
    w_last = axi_wlast_o;
    ax_hs  = axis_in_valid_i && axis_in_ready_o;
    b_hs   = axi_bvalid_i && axi_bready_o;
    if (axis_in_ready_o !== (in_data ? axi_wready_i : 1'b0)) bad_if++;
    if (axi_wvalid_o !== (in_data ? axis_in_valid_i : 1'b0)) bad_if++;
    if (busy_o) busy_high++;
    if (aw_hs) begin
      aw_addr_log.push_back(axi_awaddr_o);
      aw_len_log.push_back(axi_awlen_o);
    end
    if (w_hs) begin
      beat_log.push_back(axi_wdata_o);
      beat_last_log.push_back(w_last);
    end
    @(posedge clk);
    if (aw_hs) begin
      in_data = 1'b1;
      aw_wait = 0;
    end else if (awv) begin
      aw_wait++;
    end
    if (ax_hs) begin
      src_idx++;
      n_axis++;
    end
    if (w_hs && w_last) begin
      in_data = 1'b0;
      b_pending++;
    end
    if (b_hs) begin
      b_done++;
      b_pending--;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic start(input logic [AW-1:0] a, input int l, input logic [31:0] base);
    clr_logs();
    src_idx = 0; src_len = l; src_base = base;
    config_in_addr_i   = a;
    config_in_length_i = AW'(l);
    config_in_valid_i  = 1'b1;
    chk("cfg_ready_at_accept", 64'(config_in_ready_o), 64'd1);
    cycle();
    config_in_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 0;
    while (busy_o && budget < 2000) begin
      cycle();
      budget++;
    end
    chk($sformatf("%s_timeout", tag), 64'(budget < 2000), 64'd1);
  endtask

  // ea: up to four 16-bit addresses, el: up to four 8-bit awlen, burst 0 in LSBs.
  task automatic check_xfer(input string tag, input int nb, input logic [63:0] ea,
                            input logic [31:0] el, input logic [31:0] base, input bit exp_err);
    int total, k, len;
    total = 0;
    chk($sformatf("%s_n_aw", tag), 64'(aw_addr_log.size()), 64'(nb));
    for (int i = 0; i < nb; i++) begin
      total += int'(el[i*8 +: 8]) + 1;
      if (i < aw_addr_log.size()) begin
        chk($sformatf("%s_awaddr%0d", tag, i), 64'(aw_addr_log[i]), 64'(ea[i*16 +: 16]));
        chk($sformatf("%s_awlen%0d", tag, i), 64'(aw_len_log[i]), 64'(el[i*8 +: 8]));
      end
    end
    chk($sformatf("%s_n_beats", tag), 64'(beat_log.size()), 64'(total));
    chk($sformatf("%s_n_axis", tag), 64'(n_axis), 64'(total));
    chk($sformatf("%s_n_b", tag), 64'(b_done), 64'(nb));
    k = 0;
    for (int i = 0; i < nb; i++) begin
      len = int'(el[i*8 +: 8]);
      for (int j = 0; j <= len; j++) begin
        if (k < beat_log.size()) begin
          chk($sformatf("%s_data%0d", tag, k), 64'(beat_log[k]), 64'(base + 32'(k)));
          chk($sformatf("%s_wlast%0d", tag, k), 64'(beat_last_log[k]), 64'(j == len));
        end
        k++;
      end
    end
    chk($sformatf("%s_if_mirror", tag), 64'(bad_if), 64'd0);
    chk($sformatf("%s_error", tag), 64'(error_o), 64'(exp_err));
    chk($sformatf("%s_cfg_ready", tag), 64'(config_in_ready_o), 64'd1);
    chk($sformatf("%s_busy", tag), 64'(busy_o), 64'd0);
  endtask

  initial begin
    int budget;
    cke_i = 1'b1; arst_n_i = 1'b0;
    config_in_addr_i = '0; config_in_length_i = '0; config_in_valid_i = 1'b0;
    axis_in_data_i = '0; axis_in_valid_i = 1'b0;
    axi_awready_i = 1'b0; axi_wready_i = 1'b0; axi_bresp_i = 2'b00; axi_bvalid_i = 1'b0;
    cyc = 0; src_idx = 0; src_len = 0; src_base = '0;
    clr_logs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", 64'(config_in_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_awvalid", 64'(axi_awvalid_o), 64'd0);
    chk("rst_bready", 64'(axi_bready_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    chk("rst_awaddr", 64'(axi_awaddr_o), 64'd0);
    arst_n_i = 1'b1;
    @(negedge clk);

    // 1: single 8-beat burst
    start(16'h0100, 8, 32'hA100_0000);
    wait_idle("t1");
    check_xfer("t1", 1, 64'h0000_0000_0000_0100, 32'h0000_0007, 32'hA100_0000, 1'b0);
    chk("t1_awsize", 64'(axi_awsize_o), 64'd2);
    chk("t1_awburst", 64'(axi_awburst_o), 64'd1);
    chk("t1_awcache", 64'(axi_awcache_o), 64'd2);
    chk("t1_awid", 64'(axi_awid_o), 64'd0);
    chk("t1_wstrb", 64'(axi_wstrb_o), 64'hF);

    // 2: 20 words -> 8 + 8 + 4
    start(16'h0100, 20, 32'hA200_0000);
    wait_idle("t2");
    check_xfer("t2", 3, 64'h0000_0140_0120_0100, 32'h0003_0707, 32'hA200_0000, 1'b0);

    // 3: 4 KiB boundary split
    start(16'h0FF8, 8, 32'hA300_0000);
    wait_idle("t3");
    check_xfer("t3", 2, 64'h0000_0000_1000_0FF8, 32'h0000_0501, 32'hA300_0000, 1'b0);

    // 4: zero length
    start(16'h0500, 0, 32'hA400_0000);
    for (int i = 0; i < 6; i++) cycle();
    chk("t4_n_aw", 64'(aw_addr_log.size()), 64'd0);
    chk("t4_busy_cycles", 64'(busy_high), 64'd0);
    chk("t4_cfg_ready", 64'(config_in_ready_o), 64'd1);

    // 5: gaps on W and stream, AW ready delayed 5 cycles
    gaps = 1'b1; aw_delay = 5;
    start(16'h0200, 16, 32'hA500_0000);
    wait_idle("t5");
    check_xfer("t5", 2, 64'h0000_0000_0220_0200, 32'h0000_0707, 32'hA500_0000, 1'b0);
    gaps = 1'b0; aw_delay = 0;

    // 6: SLVERR on second B
    err_burst = 1;
    start(16'h0300, 16, 32'hA600_0000);
    wait_idle("t6");
    check_xfer("t6", 2, 64'h0000_0000_0320_0300, 32'h0000_0707, 32'hA600_0000, 1'b1);
    err_burst = -1;

    // new config clears error; then reset in the middle of DATA
    start(16'h0400, 8, 32'hA700_0000);
    chk("t7_error_cleared", 64'(error_o), 64'd0);
    budget = 0;
    while (!(in_data && beat_log.size() >= 2) && budget < 100) begin
      cycle();
      budget++;
    end
    chk("t7_reach_data", 64'(budget < 100), 64'd1);
    axis_in_valid_i = 1'b1;
    axi_wready_i    = 1'b1;
    arst_n_i        = 1'b0;
    #1;
    chk("t7_rst_awvalid", 64'(axi_awvalid_o), 64'd0);
    chk("t7_rst_wvalid", 64'(axi_wvalid_o), 64'd0);
    chk("t7_rst_bready", 64'(axi_bready_o), 64'd0);
    chk("t7_rst_axis_ready", 64'(axis_in_ready_o), 64'd0);
    chk("t7_rst_cfg_ready", 64'(config_in_ready_o), 64'd1);
    chk("t7_rst_busy", 64'(busy_o), 64'd0);
    chk("t7_rst_awlen", 64'(axi_awlen_o), 64'd0);
    chk("t7_rst_awaddr", 64'(axi_awaddr_o), 64'd0);
    @(negedge clk);
    arst_n_i = 1'b1;
    clr_logs();
    @(negedge clk);

    // 8: recovery after reset
    start(16'h0040, 4, 32'hA800_0000);
    wait_idle("t8");
    check_xfer("t8", 1, 64'h0000_0000_0000_0040, 32'h0000_0003, 32'hA800_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
